// File: rtl/window_buffer.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line memories plus three column shift registers form the window; output is one cycle behind the input.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module window_buffer #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [`WORD_SIZE-1:0] in_pixel,
    output logic [`WORD_SIZE-1:0] p1,
    output logic [`WORD_SIZE-1:0] p2,
    output logic [`WORD_SIZE-1:0] p3,
    output logic [`WORD_SIZE-1:0] p4,
    output logic [`WORD_SIZE-1:0] p5,
    output logic [`WORD_SIZE-1:0] p6,
    output logic [`WORD_SIZE-1:0] p7,
    output logic [`WORD_SIZE-1:0] p8,
    output logic [`WORD_SIZE-1:0] p9,
    output logic                  out_valid,
    output logic                  out_last
);
    localparam int W  = `WORD_SIZE;
    localparam int CW = $clog2(LINE_WIDTH);
    localparam int RW = $clog2(FRAME_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [W-1:0]  line0_mem [LINE_WIDTH];
    logic [W-1:0]  line1_mem [LINE_WIDTH];
    logic [W-1:0]  line0_rd, line1_rd;
    logic [W-1:0]  win_q [9];
    logic [W-1:0]  win_d [9];
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          accept;
    logic          col_end, row_end;

    assign accept   = in_valid && !reset;
    assign line0_rd = line0_mem[col_q];
    assign line1_rd = line1_mem[col_q];
    assign col_end  = (col_q == COL_LAST);
    assign row_end  = (row_q == ROW_LAST);

    // win index 0..8 maps to p1..p9; each row of three shifts left, new column enters on the right
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (in_valid) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            if (col_end) begin
                row_d = row_end ? '0 : row_q + 1'b1;
            end
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2]    = line1_rd;
            win_d[3]    = win_q[4];
            win_d[4]    = win_q[5];
            win_d[5]    = line0_rd;
            win_d[6]    = win_q[7];
            win_d[7]    = win_q[8];
            win_d[8]    = in_pixel;
            out_valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
            out_last_d  = row_end && col_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    // Line memories are never cleared: row restarts at 0 so stale lines are never windowed
    always_ff @(posedge clk) begin
        if (accept) begin
            line1_mem[col_q] <= line0_rd;
            line0_mem[col_q] <= in_pixel;
        end
    end

    assign p1        = win_q[0];
    assign p2        = win_q[1];
    assign p3        = win_q[2];
    assign p4        = win_q[3];
    assign p5        = win_q[4];
    assign p6        = win_q[5];
    assign p7        = win_q[6];
    assign p8        = win_q[7];
    assign p9        = win_q[8];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter LINE_WIDTH, default 640, pixels per raster line (>= 3).
REQ-002 Parameter FRAME_HEIGHT, default 480, lines per frame (>= 3).
REQ-003 Pixel width is `WORD_SIZE from global.vh for every data port.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_pixel carries a pixel this cycle.
REQ-007 in_pixel  input  `WORD_SIZE  grayscale pixel, raster order (left to right, top to bottom).
REQ-008 p1..p9  output  `WORD_SIZE each  3x3 window, row-major: p1 top-left, p9 bottom-right.
REQ-009 out_valid  output  1  p1..p9 hold a complete, valid window this cycle.
REQ-010 out_last  output  1  window is the last of the frame; qualified by out_valid.

Function
REQ-011 Two line memories, LINE_WIDTH entries each, hold the two previous lines; addressed by the column counter; read and write the same address in the same accepted cycle (read-before-write).
REQ-012 Column counter col (0..LINE_WIDTH-1) and row counter row (0..FRAME_HEIGHT-1) advance only on accepted pixels (in_valid=1).
REQ-013 On an accepted pixel: col increments; at col=LINE_WIDTH-1 col wraps to 0 and row increments; at row=FRAME_HEIGHT-1 and col=LINE_WIDTH-1 both wrap to 0 (next frame begins, no gap cycle).
REQ-014 On an accepted pixel at (row,col), three 3-deep column shift registers shift left: the new right column is {line1[col], line0[col], in_pixel} for top/middle/bottom rows; line1[col] <= line0[col]; line0[col] <= in_pixel.
REQ-015 Resulting window: p9 = pixel(row,col), p7 = pixel(row,col-2), p3 = pixel(row-2,col), p1 = pixel(row-2,col-2); centre p5 = pixel(row-1,col-1).
REQ-016 out_valid is registered: asserted the cycle after an accepted pixel with row >= 2 and col >= 2; deasserted otherwise.
REQ-017 No border padding; windows straddling a line wrap (col < 2) or frame start (row < 2) never assert out_valid.
REQ-018 out_last asserted with out_valid when the completing pixel is (FRAME_HEIGHT-1, LINE_WIDTH-1); 0 otherwise.
REQ-019 Windows per frame = (LINE_WIDTH-2) x (FRAME_HEIGHT-2).
REQ-020 in_valid=0 cycle: no counter, memory or shift-register change; p1..p9 hold; out_valid and out_last are 0 next cycle.
REQ-021 Latency: accepted pixel to its window on p1..p9 with out_valid = 1 cycle.
REQ-022 Outputs feed the Sobel window stage directly; no backpressure input exists, downstream accepts every out_valid window.

Reset
REQ-023 While reset=1 on a clock edge: col, row <= 0; p1..p9 <= 0; out_valid, out_last <= 0; in_pixel ignored.
REQ-024 Line memory contents are not cleared; stale data is never exposed because row restarts at 0 (REQ-016).
REQ-025 Reset mid-frame discards the partial frame; the first pixel after reset deasserts is pixel (0,0) of a new frame.
REQ-026 reset has priority over in_valid in the same cycle.

Verification
REQ-027 LINE_WIDTH=4, FRAME_HEIGHT=4, continuous in_valid, pixel = 16*row+col -> first out_valid the cycle after pixel 0x22 (11th accepted) with p1..p9 = 00,01,02,10,11,12,20,21,22; exactly 4 windows per frame, last (p9=0x33) has out_last=1.
REQ-028 Same frame with in_valid toggling 1/0 each cycle -> identical window sequence, out_valid only on cycles following accepted pixels, p1..p9 held between.
REQ-029 Two back-to-back frames (32 continuous pixels) -> 8 windows total; no out_valid for pixels (0..1,*) or (*,0..1) of frame 2; first frame-2 window equals REQ-027's first window.
REQ-030 Reset asserted after 6 accepted pixels, released, frame restarted -> first out_valid after 11th post-reset pixel, values as REQ-027.
REQ-031 Reset asserted in the cycle out_valid=1 -> next cycle out_valid=0, out_last=0, p1..p9=0.
REQ-032 Default parameters, 640x480 ramp frame -> 638x478 = 304964 windows, one out_last pulse.
